pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures period and high time of an incoming PWM waveform, in clock cycles.
- One sample is emitted per rising edge of the input.
- Detects stuck-low (0% duty) and stuck-high (100% duty) inputs via timeout.
- Sits at a chip input, or in loopback benches, downstream of a PWM source running on an unrelated or the same clock.

---
 rtl/pwm_capture.sv | 225 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// pwm_capture: measures period and high time (in clk cycles) of an
// asynchronous PWM input. One sample is produced per rising edge after the
// first. Inputs with 0% or 100% duty are reported through timeout and
// stuck_level.
// Optional build macro PWM_CAPTURE_DEGLITCH_EN inserts a majority-free
// run-length filter after the synchroniser that rejects pulses shorter than
// DEGLITCH_CYCLES cycles.
module pwm_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEGLITCH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH:0]   period_out,
  output logic [WIDTH:0]   high_out,
  output logic             sample_valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  // Longest measurable period; reaching it without a rise means timeout.
  localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2 || DEGLITCH_CYCLES < 2) begin : g_param_check
    $error("pwm_capture: SYNC_STAGES and DEGLITCH_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   raw_s;
  logic                   pwm_s;
  logic                   pwm_d_r;
  logic                   rise_s;

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [WIDTH:0]         per_cnt_r;
  logic [WIDTH:0]         high_cnt_r;
  logic [WIDTH:0]         per_cnt_nxt_s;
  logic [WIDTH:0]         high_cnt_nxt_s;
  logic [WIDTH:0]         period_nxt_s;
  logic [WIDTH:0]         high_nxt_s;
  logic                   valid_nxt_s;
  logic                   timeout_nxt_s;
  logic                   stuck_nxt_s;

  // Synchroniser chain for the asynchronous PWM input; runs even when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign raw_s = sync_r[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH_CYCLES);
  localparam logic [DG_W-1:0] DG_LAST = DG_W'(DEGLITCH_CYCLES - 1);

  logic            filt_r;
  logic [DG_W-1:0] dg_cnt_r;

  // Filtered level follows the synchroniser only after DEGLITCH_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_r   <= 1'b0;
      dg_cnt_r <= '0;
    end else if (raw_s == filt_r) begin
      dg_cnt_r <= '0;
    end else if (dg_cnt_r == DG_LAST) begin
      filt_r   <= raw_s;
      dg_cnt_r <= '0;
    end else begin
      dg_cnt_r <= dg_cnt_r + DG_W'(1);
    end
  end

  assign pwm_s = filt_r;
`else
  assign pwm_s = raw_s;
`endif

  // One-cycle delayed copy of the conditioned input for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_d_r <= 1'b0;
    end else begin
      pwm_d_r <= pwm_s;
    end
  end

  assign rise_s = pwm_s & ~pwm_d_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a rise always wins over the timeout condition.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) state_nxt_s = ST_MEASURE;
          else        state_nxt_s = ST_IDLE;
        end
        ST_MEASURE: begin
          if (rise_s)                   state_nxt_s = ST_MEASURE;
          else if (per_cnt_r == CNT_MAX) state_nxt_s = ST_TIMEOUT;
          else                          state_nxt_s = ST_MEASURE;
        end
        ST_TIMEOUT: begin
          if (rise_s) state_nxt_s = ST_MEASURE;
          else        state_nxt_s = ST_TIMEOUT;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: next values of counters and of the registered outputs.
  always_comb begin
    per_cnt_nxt_s  = per_cnt_r;
    high_cnt_nxt_s = high_cnt_r;
    period_nxt_s   = period_out;
    high_nxt_s     = high_out;
    valid_nxt_s    = 1'b0;
    timeout_nxt_s  = timeout;
    stuck_nxt_s    = stuck_level;
    if (!enable) begin
      per_cnt_nxt_s  = '0;
      high_cnt_nxt_s = '0;
      timeout_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timeout_nxt_s = 1'b0;
          if (rise_s) begin
            // First edge only starts a period; the preceding one was partial.
            per_cnt_nxt_s  = CNT_ONE;
            high_cnt_nxt_s = CNT_ONE;
          end else begin
            per_cnt_nxt_s  = '0;
            high_cnt_nxt_s = '0;
          end
        end
        ST_MEASURE: begin
          if (rise_s) begin
            period_nxt_s   = per_cnt_r;
            high_nxt_s     = high_cnt_r;
            valid_nxt_s    = 1'b1;
            per_cnt_nxt_s  = CNT_ONE;
            high_cnt_nxt_s = CNT_ONE;
          end else if (per_cnt_r == CNT_MAX) begin
            // Counters freeze here, so they can never wrap.
            timeout_nxt_s = 1'b1;
            stuck_nxt_s   = pwm_s;
          end else begin
            per_cnt_nxt_s  = per_cnt_r + CNT_ONE;
            high_cnt_nxt_s = high_cnt_r + {{WIDTH{1'b0}}, pwm_s};
          end
        end
        ST_TIMEOUT: begin
          if (rise_s) begin
            // Period after a stuck input is partial: restart without a sample.
            timeout_nxt_s  = 1'b0;
            per_cnt_nxt_s  = CNT_ONE;
            high_cnt_nxt_s = CNT_ONE;
          end else begin
            timeout_nxt_s = 1'b1;
          end
        end
        default: begin
          per_cnt_nxt_s  = '0;
          high_cnt_nxt_s = '0;
          timeout_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_r    <= '0;
      high_cnt_r   <= '0;
      period_out   <= '0;
      high_out     <= '0;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      per_cnt_r    <= per_cnt_nxt_s;
      high_cnt_r   <= high_cnt_nxt_s;
      period_out   <= period_nxt_s;
      high_out     <= high_nxt_s;
      sample_valid <= valid_nxt_s;
      timeout      <= timeout_nxt_s;
      stuck_level  <= stuck_nxt_s;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Directed self-checking bench for pwm_capture (WIDTH=8, SYNC_STAGES=2).
module tb_pwm_capture;

  localparam int WIDTH = 8;
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int DG    = 3;
  localparam int P3_HI = 4;
`else
  localparam int DG    = 0;
  localparam int P3_HI = 6;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b1;
  logic           pwm_in = 1'b0;
  logic [WIDTH:0] period_out;
  logic [WIDTH:0] high_out;
  logic           sample_valid;
  logic           timeout;
  logic           stuck_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int q_per[$];
  int q_high[$];
  int q_cyc[$];
  int base;
  int n;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEGLITCH_CYCLES(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .sample_valid (sample_valid),
    .timeout      (timeout),
    .stuck_level  (stuck_level)
  );

  // Record every emitted sample, sampled away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid === 1'b1) begin
      q_per.push_back(int'(period_out));
      q_high.push_back(int'(high_out));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic pwm_cycles(input int hi, input int lo, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // 20-cycle period, high 5, with a 1-cycle glitch in the middle of the low phase.
  task automatic glitch_period();
    pwm_in = 1'b1; repeat (5) @(negedge clk);
    pwm_in = 1'b0; repeat (7) @(negedge clk);
    pwm_in = 1'b1; repeat (1) @(negedge clk);
    pwm_in = 1'b0; repeat (7) @(negedge clk);
  endtask

  function automatic int last_per();
    if (q_per.size() > 0) return q_per[q_per.size()-1];
    else return -1;
  endfunction

  function automatic int last_high();
    if (q_high.size() > 0) return q_high[q_high.size()-1];
    else return -1;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_period", period_out, 0);
    chk("rst_high", high_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_stuck", stuck_level, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 256/128: three rises give two samples, 256 cycles apart
    base = q_per.size();
    pwm_cycles(128, 128, 3);
    chk("p256_count", q_per.size() - base, 2);
    chk("p256_period", last_per(), 256);
    chk("p256_high", last_high(), 128);
    chk("p256_spacing", (q_cyc.size() >= 2) ? q_cyc[q_cyc.size()-1] - q_cyc[q_cyc.size()-2] : -1, 256);

    // 10/3: first sample closes the final 256 period
    base = q_per.size();
    pwm_cycles(3, 7, 4);
    chk("p10_count", q_per.size() - base, 4);
    chk("p10_first", (q_per.size() > base) ? q_per[base] : -1, 256);
    chk("p10_period", last_per(), 10);
    chk("p10_high", last_high(), 3);

    // Switch to period 7: first sample spans the switch (10/3)
    base = q_per.size();
    pwm_cycles(P3_HI, 7 - P3_HI, 3);
    chk("p7_count", q_per.size() - base, 3);
    chk("p7_first", (q_per.size() > base) ? q_per[base] : -1, 10);
    chk("p7_period", last_per(), 7);
    chk("p7_high", last_high(), P3_HI);

    // One more rise, then held low: timeout 256 cycles after the rise is seen
    base = q_per.size();
    pwm_in = 1'b1;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == P3_HI) pwm_in = 1'b0;
      if (timeout === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("low_to_latency", n, 259 + DG);
    chk("low_stuck", stuck_level, 0);
    chk("low_count", q_per.size() - base, 1);
    chk("low_period_hold", period_out, 7);
    chk("low_high_hold", high_out, P3_HI);

    // Recovery: first rise clears timeout without a sample, second rise samples
    base = q_per.size();
    pwm_cycles(3, 7, 1);
    chk("rec_timeout", timeout, 0);
    chk("rec_count1", q_per.size() - base, 0);
    pwm_cycles(3, 7, 1);
    chk("rec_count2", q_per.size() - base, 1);
    chk("rec_period", last_per(), 10);

    // Held high: one sample from the rise, then timeout with stuck_level=1
    base = q_per.size();
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("high_timeout", timeout, 1);
    chk("high_stuck", stuck_level, 1);
    chk("high_count", q_per.size() - base, 1);
    chk("high_period_hold", period_out, 10);
    chk("high_high_hold", high_out, 3);

    // Enable dropped for 5 cycles while timed out
    base = q_per.size();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_timeout", timeout, 0);
    chk("en_valid", sample_valid, 0);
    chk("en_period_hold", period_out, 10);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (7 + DG) @(negedge clk);
    pwm_cycles(3, 7, 1);
    chk("en_count1", q_per.size() - base, 0);
    pwm_cycles(3, 7, 1);
    chk("en_count2", q_per.size() - base, 1);
    chk("en_period", last_per(), 10);

    // Reset pulsed mid-period
    pwm_in = 1'b1; repeat (3) @(negedge clk);
    pwm_in = 1'b0; repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_period", period_out, 0);
    chk("mid_rst_high", high_out, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_stuck", stuck_level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    base = q_per.size();
    pwm_cycles(3, 7, 1);
    chk("rst_rec_count1", q_per.size() - base, 0);
    pwm_cycles(3, 7, 1);
    chk("rst_rec_count2", q_per.size() - base, 1);
    chk("rst_rec_high", last_high(), 3);

    // 20/5 waveform with a 1-cycle glitch in the low phase
    base = q_per.size();
    for (int k = 0; k < 4; k++) glitch_period();
    pwm_cycles(5, 15, 1);
    repeat (8) @(negedge clk);
`ifdef PWM_CAPTURE_DEGLITCH_EN
    chk("glitch_count", q_per.size() - base, 5);
    chk("glitch_period", last_per(), 20);
    chk("glitch_high", last_high(), 5);
`else
    chk("glitch_count", q_per.size() - base, 9);
    chk("glitch_period", last_per(), 8);
    chk("glitch_high", last_high(), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
